// File: rtl/mul_acc.sv
// -----------------------------------------------------------------------------
// mul_acc -- signed fixed-point product accumulator (neuron pre-activation)
//
// Sums a programmed number of product strobes from the upstream multiplier
// onto a bias term. The sum is kept in a wide accumulator and saturated to
// WIDTH bits once at the end. Bias, products and result all use the same Qm.n
// format, so no alignment shift is applied. FBITS only documents that format.
//
// Optional build macro:
//   MUL_ACC_RELU_EN  when defined, a negative saturated result is replaced by 0.
//                    ovf and valid are computed before the ReLU and do not
//                    change.
//
// Ports:
//   clk        in   clock
//   rst        in   asynchronous, active-high reset
//   start      in   begin accumulation (sampled only in IDLE)
//   len        in   number of products, 0..NMAX (larger values clamp to NMAX)
//   bias       in   signed initial accumulator value
//   prod_done  in   one-cycle product strobe from the multiplier
//   prod_val   in   signed product, qualified by prod_done
//   prod_ovf   in   multiplier overflow flag, qualified by prod_done
//   busy       out  accumulation in progress
//   done       out  one-cycle result strobe
//   valid      out  result valid (no saturation and no upstream overflow)
//   ovf        out  saturation or any upstream product overflow
//   val        out  signed saturated result
//
// Handshake: there is no backpressure. start is accepted on any clock edge
// where the FSM is IDLE. Each prod_done edge seen in ACC consumes exactly one
// product. done pulses for one cycle, and valid/ovf/val hold after done until
// the next accepted start or a reset.
// -----------------------------------------------------------------------------
module mul_acc #(
   parameter int WIDTH = 8,
   parameter int FBITS = 4,
   parameter int NMAX  = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [$clog2(NMAX+1)-1:0]  len,
   input  logic [WIDTH-1:0]           bias,
   input  logic                       prod_done,
   input  logic [WIDTH-1:0]           prod_val,
   input  logic                       prod_ovf,
   output logic                       busy,
   output logic                       done,
   output logic                       valid,
   output logic                       ovf,
   output logic [WIDTH-1:0]           val
);

   localparam int LW   = $clog2(NMAX+1);
   // One guard bit beyond the worst-case growth of NMAX+1 terms, so the
   // running sum can never wrap.
   localparam int ACCW = WIDTH + LW + 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ACC  = 2'd1;
   localparam logic [1:0] SAT  = 2'd2;

   localparam logic [LW-1:0]          NMAX_L  = LW'(NMAX);
   localparam logic [LW-1:0]          CNT_ONE = LW'(1);
   localparam logic signed [ACCW-1:0] MAX_V   = ACCW'((64'sd1 <<< (WIDTH-1)) - 64'sd1);
   localparam logic signed [ACCW-1:0] MIN_V   = -MAX_V - ACCW'(1);

   logic [1:0]             state;
   logic signed [ACCW-1:0] acc;
   logic [LW-1:0]          cnt;
   logic                   sticky;

   logic [LW-1:0]          len_eff;
   logic signed [ACCW-1:0] bias_ext;
   logic signed [ACCW-1:0] prod_ext;
   logic [WIDTH-1:0]       sat_val;
   logic [WIDTH-1:0]       out_val;
   logic                   sat;

   assign len_eff  = (len > NMAX_L) ? NMAX_L : len;
   assign bias_ext = {{(ACCW-WIDTH){bias[WIDTH-1]}}, bias};
   assign prod_ext = {{(ACCW-WIDTH){prod_val[WIDTH-1]}}, prod_val};

   // Clamp the wide sum into the WIDTH-bit signed range.
   always_comb begin
      sat_val = acc[WIDTH-1:0];
      sat     = 1'b0;
      if (acc > MAX_V) begin
         sat_val = MAX_V[WIDTH-1:0];
         sat     = 1'b1;
      end else if (acc < MIN_V) begin
         sat_val = MIN_V[WIDTH-1:0];
         sat     = 1'b1;
      end
      out_val = sat_val;
`ifdef MUL_ACC_RELU_EN
      if (sat_val[WIDTH-1]) begin
         out_val = '0;
      end
`else
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         acc    <= '0;
         cnt    <= '0;
         sticky <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         valid  <= 1'b0;
         ovf    <= 1'b0;
         val    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  acc    <= bias_ext;
                  cnt    <= len_eff;
                  sticky <= 1'b0;
                  busy   <= 1'b1;
                  valid  <= 1'b0;
                  ovf    <= 1'b0;
                  state  <= (len_eff == '0) ? SAT : ACC;
               end
            end
            ACC: begin
               if (prod_done) begin
                  acc    <= acc + prod_ext;
                  sticky <= sticky | prod_ovf;
                  cnt    <= cnt - CNT_ONE;
                  if (cnt == CNT_ONE) begin
                     state <= SAT;
                  end
               end
            end
            SAT: begin
               val   <= out_val;
               ovf   <= sat | sticky;
               valid <= ~(sat | sticky);
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_acc.sv
// -----------------------------------------------------------------------------
// tb_mul_acc -- directed self-checking bench for mul_acc (WIDTH=8, NMAX=16).
// Inputs are driven on the falling edge and outputs are sampled on the falling
// edge, away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_mul_acc;

   localparam int WIDTH = 8;
   localparam int NMAX  = 16;
   localparam int LW    = $clog2(NMAX+1);
   localparam int WAIT_BOUND = 40;

   logic             clk;
   logic             rst;
   logic             start;
   logic [LW-1:0]    len;
   logic [WIDTH-1:0] bias;
   logic             prod_done;
   logic [WIDTH-1:0] prod_val;
   logic             prod_ovf;
   logic             busy;
   logic             done;
   logic             valid;
   logic             ovf;
   logic [WIDTH-1:0] val;

   int total;
   int bad;

   mul_acc #(.WIDTH(WIDTH), .FBITS(4), .NMAX(NMAX)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .len       (len),
      .bias      (bias),
      .prod_done (prod_done),
      .prod_val  (prod_val),
      .prod_ovf  (prod_ovf),
      .busy      (busy),
      .done      (done),
      .valid     (valid),
      .ovf       (ovf),
      .val       (val)
   );

   // ---------------------------------------------------------------- clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // --------------------------------------------------------- driver tasks
   task automatic start_acc(input logic [WIDTH-1:0] b, input logic [LW-1:0] l);
      start = 1'b1;
      bias  = b;
      len   = l;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_prod(input logic [WIDTH-1:0] v, input logic o);
      prod_done = 1'b1;
      prod_val  = v;
      prod_ovf  = o;
      @(negedge clk);
      prod_done = 1'b0;
      prod_ovf  = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // Returns at the falling edge where done is high, or when the bound expires.
   task automatic wait_done(output logic found, output int cycles);
      found  = 1'b0;
      cycles = 0;
      while (!found && cycles < WAIT_BOUND) begin
         if (done) found = 1'b1;
         else begin
            @(negedge clk);
            cycles++;
         end
      end
   endtask

   // ----------------------------------------------------------- scenarios
   task automatic test_reset;
      rst = 1'b1; start = 1'b0; len = '0; bias = '0;
      prod_done = 1'b0; prod_val = '0; prod_ovf = 1'b0;
      idle_cycles(3);
      rst = 1'b0;
      @(negedge clk);
      total++;
      if ({busy, done, valid, ovf, val} !== 12'h000) begin
         bad++;
         $display("FAIL reset_outputs got busy=%b done=%b valid=%b ovf=%b val=%h want all 0",
                  busy, done, valid, ovf, val);
      end
   endtask

   task automatic test_basic_sum;
      logic found; int cyc;
      start_acc(8'h10, 5'd3);
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got %b want 1", busy); end
      send_prod(8'h20, 1'b0);
      send_prod(8'h08, 1'b0);
      send_prod(8'hF0, 1'b0);
      wait_done(found, cyc);
      total++;
      if (!found) begin bad++; $display("FAIL basic_done_timeout got none want done"); end
      total++;
      if ({val, valid, ovf} !== {8'h28, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL basic_result got val=%h valid=%b ovf=%b want val=28 valid=1 ovf=0", val, valid, ovf);
      end
      @(negedge clk);
      total++;
      if ({done, busy} !== 2'b00) begin
         bad++;
         $display("FAIL basic_pulse got done=%b busy=%b want 0 0", done, busy);
      end
      idle_cycles(3);
      total++;
      if ({val, valid, ovf} !== {8'h28, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL basic_hold got val=%h valid=%b ovf=%b want 28 1 0", val, valid, ovf);
      end
   endtask

   task automatic test_saturation;
      logic found; int cyc;
      logic [WIDTH-1:0] exp_neg;
`ifdef MUL_ACC_RELU_EN
      exp_neg = 8'h00;
`else
      exp_neg = 8'h80;
`endif
      // 0x70 + 0x70 + 0x70 = 336 -> clamps to +127
      start_acc(8'h70, 5'd2);
      send_prod(8'h70, 1'b0);
      send_prod(8'h70, 1'b0);
      wait_done(found, cyc);
      total++;
      if (!found || {val, valid, ovf} !== {8'h7F, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL sat_pos got found=%b val=%h valid=%b ovf=%b want 7f 0 1", found, val, valid, ovf);
      end
      @(negedge clk);
      // -128 + -128 = -256 -> clamps to -128
      start_acc(8'h80, 5'd1);
      send_prod(8'h80, 1'b0);
      wait_done(found, cyc);
      total++;
      if (!found || {val, valid, ovf} !== {exp_neg, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL sat_neg got found=%b val=%h valid=%b ovf=%b want %h 0 1",
                  found, val, valid, ovf, exp_neg);
      end
      @(negedge clk);
      // 112 + 112 - 112 = 112: the wide accumulator absorbs the excursion
      start_acc(8'h70, 5'd2);
      send_prod(8'h70, 1'b0);
      send_prod(8'h90, 1'b0);
      wait_done(found, cyc);
      total++;
      if (!found || {val, valid, ovf} !== {8'h70, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL excursion got found=%b val=%h valid=%b ovf=%b want 70 1 0", found, val, valid, ovf);
      end
      @(negedge clk);
   endtask

   task automatic test_upstream_ovf_len0;
      logic found; int cyc;
      start_acc(8'h00, 5'd1);
      send_prod(8'h10, 1'b1);
      wait_done(found, cyc);
      total++;
      if (!found || {val, valid, ovf} !== {8'h10, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL upstream_ovf got found=%b val=%h valid=%b ovf=%b want 10 0 1", found, val, valid, ovf);
      end
      @(negedge clk);
      // len=0: done rises on the edge after the start edge
      start_acc(8'h33, 5'd0);
      wait_done(found, cyc);
      total++;
      if (!found || cyc !== 1) begin
         bad++;
         $display("FAIL len0_latency got found=%b cycles=%0d want 1", found, cyc);
      end
      total++;
      if ({val, valid, ovf} !== {8'h33, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL len0_result got val=%h valid=%b ovf=%b want 33 1 0", val, valid, ovf);
      end
      @(negedge clk);
   endtask

   task automatic test_protocol_edges;
      logic found; int cyc;
      // Stray strobe while idle must not be counted or flagged
      send_prod(8'h40, 1'b1);
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL stray_busy got %b want 0", busy); end
      start_acc(8'h00, 5'd1);
      send_prod(8'h05, 1'b0);
      wait_done(found, cyc);
      total++;
      if (!found || {val, valid, ovf} !== {8'h05, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL stray_result got found=%b val=%h valid=%b ovf=%b want 05 1 0", found, val, valid, ovf);
      end
      @(negedge clk);
      // start during ACC is ignored
      start_acc(8'h10, 5'd2);
      send_prod(8'h01, 1'b0);
      start_acc(8'h50, 5'd1);
      send_prod(8'h02, 1'b0);
      wait_done(found, cyc);
      total++;
      if (!found || {val, valid} !== {8'h13, 1'b1}) begin
         bad++;
         $display("FAIL start_in_acc got found=%b val=%h valid=%b want 13 1", found, val, valid);
      end
      @(negedge clk);
      // Five idle cycles between strobes
      start_acc(8'h00, 5'd3);
      send_prod(8'h01, 1'b0);
      idle_cycles(5);
      send_prod(8'h02, 1'b0);
      idle_cycles(5);
      send_prod(8'h03, 1'b0);
      wait_done(found, cyc);
      total++;
      if (!found || {val, valid} !== {8'h06, 1'b1}) begin
         bad++;
         $display("FAIL gaps got found=%b val=%h valid=%b want 06 1", found, val, valid);
      end
      @(negedge clk);
      // len=NMAX+1 clamps to NMAX: 16 products of 1 complete the run
      start_acc(8'h00, 5'(NMAX+1));
      for (int i = 0; i < NMAX; i++) send_prod(8'h01, 1'b0);
      wait_done(found, cyc);
      total++;
      if (!found || {val, valid} !== {8'h10, 1'b1}) begin
         bad++;
         $display("FAIL len_clamp got found=%b val=%h valid=%b want 10 1", found, val, valid);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      logic found; int cyc;
      start_acc(8'h01, 5'd1);
      send_prod(8'h01, 1'b0);
      wait_done(found, cyc);
      total++;
      if (!found || val !== 8'h02) begin
         bad++;
         $display("FAIL b2b_first got found=%b val=%h want 02", found, val);
      end
      // Launch on the done cycle itself
      start_acc(8'h02, 5'd1);
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy got %b want 1", busy); end
      send_prod(8'h03, 1'b0);
      wait_done(found, cyc);
      total++;
      if (!found || {val, valid, ovf} !== {8'h05, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL b2b_second got found=%b val=%h valid=%b ovf=%b want 05 1 0", found, val, valid, ovf);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_op;
      logic found; int cyc;
      start_acc(8'h10, 5'd3);
      send_prod(8'h20, 1'b0);
      #2 rst = 1'b1;
      #1;
      total++;
      if ({busy, done, valid, ovf, val} !== 12'h000) begin
         bad++;
         $display("FAIL reset_async got busy=%b done=%b valid=%b ovf=%b val=%h want all 0",
                  busy, done, valid, ovf, val);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      start_acc(8'h01, 5'd1);
      send_prod(8'h02, 1'b0);
      wait_done(found, cyc);
      total++;
      if (!found || {val, valid, ovf} !== {8'h03, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL reset_recover got found=%b val=%h valid=%b ovf=%b want 03 1 0", found, val, valid, ovf);
      end
      @(negedge clk);
   endtask

   // ---------------------------------------------------------------- main
   initial begin
      total = 0;
      bad   = 0;
      @(negedge clk);
      test_reset();
      test_basic_sum();
      test_saturation();
      test_upstream_ovf_len0();
      test_protocol_edges();
      test_back_to_back();
      test_reset_mid_op();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
